stack_engine: RTL and testbench

Multi-cycle stack sequencer that drives the special-register write ports for SP, LR and PC. It executes PUSH, POP, CALL and RET commands from the control unit. Each command reads the current SP/LR/PC values and performs one handshaked data-memory access. It then commits the new register values in a single strobe cycle. This block keeps the full-descending stack and the call/return linkage consistent, so the control unit never sequences SP, LR and PC writes by hand.

---
 rtl/stack_pkg.sv | 23 ++
 rtl/stack_bounds_chk.sv | 20 ++
 rtl/stack_engine.sv | 94 +++++++++
 tb/tb_stack_engine.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// stack_pkg: shared encodings and constants for the stack engine
package stack_pkg;
  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_t;
  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_MEM,
    S_COMMIT
  } state_t;
  localparam logic [1:0] FC_NONE      = 2'b00;
  localparam logic [1:0] FC_OVERFLOW  = 2'b01;
  localparam logic [1:0] FC_UNDERFLOW = 2'b10;
  localparam logic [1:0] FC_MISALIGN  = 2'b11;
  localparam logic [31:0] WORD_BYTES = 32'd4;
  function automatic logic grows(input op_t op);
    return op == OP_PUSH || op == OP_CALL;
  endfunction
endpackage

// File: rtl/stack_bounds_chk.sv
// stack_bounds_chk: combinational misalign/overflow/underflow decision for a stack op
module stack_bounds_chk
  import stack_pkg::*;
#(
  parameter logic [31:0] STACK_BASE  = 32'h0000_1000,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0800
) (
  input  logic [31:0] sp,
  input  op_t         op,
  output logic        fault,
  output logic [1:0]  code
);
  // misalignment dominates; otherwise the direction of the op picks which bound applies
  always_comb begin
    code  = sp[1:0] != 2'b00 ? FC_MISALIGN :
            grows(op) ? (sp - WORD_BYTES < STACK_LIMIT ? FC_OVERFLOW : FC_NONE) :
            (sp >= STACK_BASE ? FC_UNDERFLOW : FC_NONE);
    fault = code != FC_NONE;
  end
endmodule

// File: rtl/stack_engine.sv
// stack_engine: sequences PUSH/POP/CALL/RET into one memory access and one SP/LR/PC commit
module stack_engine
  import stack_pkg::*;
#(
  parameter logic [31:0] STACK_BASE  = 32'h0000_1000,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  input  logic [31:0] sp_in,
  input  logic [31:0] lr_in,
  input  logic [31:0] pc_in,
  output logic        wr_sp,
  output logic        wr_lr,
  output logic        wr_pc,
  output logic [31:0] wr_sp_data,
  output logic [31:0] wr_lr_data,
  output logic [31:0] wr_pc_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        pop_valid,
  output logic [31:0] pop_data,
  output logic        fault,
  output logic [1:0]  fault_code
);
  state_t      state, state_nx;
  op_t         op_q;
  logic [31:0] data_q, sp_q, lr_q, pc_q, rd_q;
  logic        chk_fault, grow, link, commit;
  logic [1:0]  chk_code;
  stack_bounds_chk #(
    .STACK_BASE (STACK_BASE),
    .STACK_LIMIT(STACK_LIMIT)
  ) u_chk (
    .sp   (sp_q),
    .op   (op_q),
    .fault(chk_fault),
    .code (chk_code)
  );
  // state register; command operands are snapshotted on acceptance, read data on ack
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      op_q   <= OP_PUSH;
      data_q <= '0;
      sp_q   <= '0;
      lr_q   <= '0;
      pc_q   <= '0;
      rd_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && cmd_valid) begin
        op_q   <= op_t'(cmd_op);
        data_q <= cmd_data;
        sp_q   <= sp_in;
        lr_q   <= lr_in;
        pc_q   <= pc_in;
      end
      if (state == S_MEM && mem_ack) rd_q <= mem_rdata;
    end
  end
  // next state and state-decoded outputs; data outputs are zero outside their strobe
  always_comb begin
    state_nx   = state == S_IDLE  ? (cmd_valid ? S_CHECK : S_IDLE) :
                 state == S_CHECK ? (chk_fault ? S_IDLE : S_MEM) :
                 state == S_MEM   ? (mem_ack ? S_COMMIT : S_MEM) : S_IDLE;
    grow       = grows(op_q);
    link       = op_q == OP_CALL || op_q == OP_RET;
    commit     = state == S_COMMIT;
    cmd_ready  = state == S_IDLE;
    fault      = state == S_CHECK && chk_fault;
    fault_code = fault ? chk_code : FC_NONE;
    mem_req    = state == S_MEM;
    mem_we     = mem_req && grow;
    mem_addr   = mem_req ? (grow ? sp_q - WORD_BYTES : sp_q) : '0;
    mem_wdata  = mem_we ? (op_q == OP_PUSH ? data_q : lr_q) : '0;
    wr_sp      = commit;
    wr_sp_data = commit ? (grow ? sp_q - WORD_BYTES : sp_q + WORD_BYTES) : '0;
    wr_lr      = commit && link;
    wr_lr_data = wr_lr ? (op_q == OP_CALL ? pc_q + WORD_BYTES : rd_q) : '0;
    wr_pc      = commit && link;
    wr_pc_data = wr_pc ? (op_q == OP_CALL ? data_q & ~32'd3 : lr_q) : '0;
    pop_valid  = commit && op_q == OP_POP;
    pop_data   = pop_valid ? rd_q : '0;
  end
endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine: scoreboard-driven checks of stack_engine commands, faults and reset
module tb_stack_engine;
  import stack_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_data = '0, sp_in = '0, lr_in = '0, pc_in = '0, mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        cmd_ready, wr_sp, wr_lr, wr_pc, mem_req, mem_we, pop_valid, fault;
  logic [31:0] wr_sp_data, wr_lr_data, wr_pc_data, mem_addr, mem_wdata, pop_data;
  logic [1:0]  fault_code;
  int checks = 0;
  int fails = 0;
  logic [31:0] mem_model [logic [31:0]];

  typedef struct packed {
    bit          mem_seen;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    int          req_cycles;
    bit          unstable;
    int          n_wsp;
    int          n_wlr;
    int          n_wpc;
    int          n_pop;
    int          n_fault;
    logic [31:0] sp_data;
    logic [31:0] lr_data;
    logic [31:0] pc_data;
    logic [31:0] pop_data;
    logic [1:0]  fcode;
    int          commit_at;
    int          fault_at;
    int          ready_at;
  } obs_t;

  obs_t exp_q[$];

  always #5 clk = ~clk;

  stack_engine dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .sp_in(sp_in), .lr_in(lr_in), .pc_in(pc_in),
    .wr_sp(wr_sp), .wr_lr(wr_lr), .wr_pc(wr_pc),
    .wr_sp_data(wr_sp_data), .wr_lr_data(wr_lr_data), .wr_pc_data(wr_pc_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pop_valid(pop_valid), .pop_data(pop_data),
    .fault(fault), .fault_code(fault_code)
  );

  // Offers one command at the current negedge and records what the engine does until idle.
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] data, input logic [31:0] sp,
                         input logic [31:0] lr, input logic [31:0] pc, input int wait_n,
                         input bit stray, output obs_t o);
    o = '0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; sp_in = sp; lr_in = lr; pc_in = pc;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        cmd_valid = 1'b0; cmd_data = 32'h5555_5555;
        sp_in = 32'hA5A5_A5A4; lr_in = 32'h1111_1110; pc_in = 32'h2222_2220;
      end
      mem_rdata = 32'hBAD0_BAD0;
      if (mem_req) begin
        if (o.req_cycles == 0) begin
          o.mem_seen = 1'b1; o.addr = mem_addr; o.we = mem_we; o.wdata = mem_wdata;
        end else if (mem_addr !== o.addr || mem_we !== o.we || mem_wdata !== o.wdata) o.unstable = 1'b1;
        o.req_cycles++;
        mem_ack = o.req_cycles > wait_n;
        if (mem_ack && mem_we) mem_model[mem_addr] = mem_wdata;
        if (mem_ack && !mem_we) mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
      end else mem_ack = stray;
      if (wr_sp) begin o.n_wsp++; o.sp_data = wr_sp_data; o.commit_at = n; end
      if (wr_lr) begin o.n_wlr++; o.lr_data = wr_lr_data; end
      if (wr_pc) begin o.n_wpc++; o.pc_data = wr_pc_data; end
      if (pop_valid) begin o.n_pop++; o.pop_data = pop_data; end
      if (fault) begin o.n_fault++; o.fcode = fault_code; o.fault_at = n; end
      if (cmd_ready) begin o.ready_at = n; break; end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    checks++; if ({mem_req, mem_we, wr_sp, wr_lr, wr_pc, pop_valid, fault} !== 7'b0) begin
      fails++; $display("FAIL reset_strobes: got %b expected 0000000", {mem_req, mem_we, wr_sp, wr_lr, wr_pc, pop_valid, fault}); end
    checks++; if ((mem_addr | mem_wdata | wr_sp_data | wr_lr_data | wr_pc_data | pop_data) !== 32'h0 || fault_code !== 2'b00) begin
      fails++; $display("FAIL reset_data: got addr %h code %b expected 0", mem_addr, fault_code); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_push();
    obs_t o, e;
    e = '0; e.addr = 32'h0FFC; e.wdata = 32'hDEAD_BEEF; e.sp_data = 32'h0FFC; e.commit_at = 3; e.ready_at = 4;
    exp_q.push_back(e);
    run_cmd(OP_PUSH, 32'hDEAD_BEEF, 32'h1000, 32'h0, 32'h0, 0, 1'b0, o);
    e = exp_q.pop_front();
    checks++; if (o.addr !== e.addr || o.we !== 1'b1) begin fails++; $display("FAIL push_addr: got %h we %b expected %h we 1", o.addr, o.we, e.addr); end
    checks++; if (o.wdata !== e.wdata) begin fails++; $display("FAIL push_wdata: got %h expected %h", o.wdata, e.wdata); end
    checks++; if (o.n_wsp != 1 || o.sp_data !== e.sp_data) begin fails++; $display("FAIL push_sp: got %0d x %h expected 1 x %h", o.n_wsp, o.sp_data, e.sp_data); end
    checks++; if (o.n_wlr + o.n_wpc + o.n_pop + o.n_fault != 0) begin fails++; $display("FAIL push_extra: got %0d extra pulses expected 0", o.n_wlr + o.n_wpc + o.n_pop + o.n_fault); end
    checks++; if (o.commit_at != e.commit_at || o.ready_at != e.ready_at) begin
      fails++; $display("FAIL push_timing: got commit %0d ready %0d expected %0d %0d", o.commit_at, o.ready_at, e.commit_at, e.ready_at); end
  endtask

  task automatic test_pop_wait();
    obs_t o, e;
    mem_model[32'h0FFC] = 32'h1234_5678;
    e = '0; e.addr = 32'h0FFC; e.pop_data = 32'h1234_5678; e.sp_data = 32'h1000; e.req_cycles = 4; e.commit_at = 6; e.ready_at = 7;
    exp_q.push_back(e);
    run_cmd(OP_POP, 32'h0, 32'h0FFC, 32'h0, 32'h0, 3, 1'b1, o);
    e = exp_q.pop_front();
    checks++; if (o.addr !== e.addr || o.we !== 1'b0) begin fails++; $display("FAIL pop_addr: got %h we %b expected %h we 0", o.addr, o.we, e.addr); end
    checks++; if (o.req_cycles != e.req_cycles || o.unstable) begin fails++; $display("FAIL pop_req_hold: got %0d cycles unstable %b expected %0d stable", o.req_cycles, o.unstable, e.req_cycles); end
    checks++; if (o.n_pop != 1 || o.pop_data !== e.pop_data) begin fails++; $display("FAIL pop_data: got %0d x %h expected 1 x %h", o.n_pop, o.pop_data, e.pop_data); end
    checks++; if (o.sp_data !== e.sp_data || o.n_wlr + o.n_wpc != 0) begin fails++; $display("FAIL pop_sp: got %h lr/pc %0d expected %h 0", o.sp_data, o.n_wlr + o.n_wpc, e.sp_data); end
    checks++; if (o.commit_at != e.commit_at || o.ready_at != e.ready_at) begin
      fails++; $display("FAIL pop_timing: got commit %0d ready %0d expected %0d %0d", o.commit_at, o.ready_at, e.commit_at, e.ready_at); end
  endtask

  task automatic test_call();
    obs_t o, e;
    e = '0; e.addr = 32'h0FFC; e.wdata = 32'h40; e.sp_data = 32'h0FFC; e.lr_data = 32'h104; e.pc_data = 32'h2000; e.commit_at = 3;
    exp_q.push_back(e);
    run_cmd(OP_CALL, 32'h0000_2003, 32'h1000, 32'h40, 32'h100, 0, 1'b0, o);
    e = exp_q.pop_front();
    checks++; if (o.addr !== e.addr || o.wdata !== e.wdata || o.we !== 1'b1) begin
      fails++; $display("FAIL call_mem: got %h<=%h expected %h<=%h", o.addr, o.wdata, e.addr, e.wdata); end
    checks++; if (o.n_wsp != 1 || o.n_wlr != 1 || o.n_wpc != 1 || o.n_pop != 0) begin
      fails++; $display("FAIL call_strobes: got sp%0d lr%0d pc%0d pop%0d expected 1 1 1 0", o.n_wsp, o.n_wlr, o.n_wpc, o.n_pop); end
    checks++; if (o.sp_data !== e.sp_data || o.lr_data !== e.lr_data || o.pc_data !== e.pc_data) begin
      fails++; $display("FAIL call_commit: got %h %h %h expected %h %h %h", o.sp_data, o.lr_data, o.pc_data, e.sp_data, e.lr_data, e.pc_data); end
    checks++; if (o.commit_at != e.commit_at) begin fails++; $display("FAIL call_timing: got %0d expected %0d", o.commit_at, e.commit_at); end
  endtask

  task automatic test_ret();
    obs_t o, e;
    mem_model[32'h0FFC] = 32'h40;
    e = '0; e.addr = 32'h0FFC; e.sp_data = 32'h1000; e.lr_data = 32'h40; e.pc_data = 32'h104;
    exp_q.push_back(e);
    run_cmd(OP_RET, 32'h0, 32'h0FFC, 32'h104, 32'h2000, 1, 1'b0, o);
    e = exp_q.pop_front();
    checks++; if (o.addr !== e.addr || o.we !== 1'b0) begin fails++; $display("FAIL ret_addr: got %h we %b expected %h we 0", o.addr, o.we, e.addr); end
    checks++; if (o.sp_data !== e.sp_data || o.lr_data !== e.lr_data || o.pc_data !== e.pc_data || o.n_pop != 0) begin
      fails++; $display("FAIL ret_commit: got %h %h %h expected %h %h %h", o.sp_data, o.lr_data, o.pc_data, e.sp_data, e.lr_data, e.pc_data); end
  endtask

  task automatic test_faults();
    logic [1:0]  ops [3] = '{OP_POP, OP_PUSH, OP_PUSH};
    logic [31:0] sps [3] = '{32'h1000, 32'h0800, 32'h0FFE};
    logic [1:0]  codes [3] = '{FC_UNDERFLOW, FC_OVERFLOW, FC_MISALIGN};
    obs_t o, e;
    for (int i = 0; i < 3; i++) begin
      e = '0; e.fcode = codes[i]; e.fault_at = 1; e.ready_at = 2;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      run_cmd(ops[i], 32'h7777_7777, sps[i], 32'h0, 32'h0, 0, 1'b0, o);
      e = exp_q.pop_front();
      checks++; if (o.n_fault != 1 || o.fcode !== e.fcode) begin fails++; $display("FAIL fault_code[%0d]: got %0d x %b expected 1 x %b", i, o.n_fault, o.fcode, e.fcode); end
      checks++; if (o.mem_seen || o.n_wsp + o.n_wlr + o.n_wpc + o.n_pop != 0) begin
        fails++; $display("FAIL fault_side_effect[%0d]: got mem %b strobes %0d expected 0 0", i, o.mem_seen, o.n_wsp + o.n_wlr + o.n_wpc + o.n_pop); end
      checks++; if (o.fault_at != e.fault_at || o.ready_at != e.ready_at) begin
        fails++; $display("FAIL fault_timing[%0d]: got fault %0d ready %0d expected %0d %0d", i, o.fault_at, o.ready_at, e.fault_at, e.ready_at); end
    end
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    obs_t o, e;
    cmd_valid = 1'b1; cmd_op = OP_POP; sp_in = 32'h0FFC;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rst_mid_req_before: got %b expected 1", mem_req); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_mid_req_after: got %b expected 0", mem_req); end
    if (wr_sp | wr_lr | wr_pc | pop_valid) strobes++;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wr_sp | wr_lr | wr_pc | pop_valid | mem_req) strobes++;
    end
    checks++; if (strobes != 0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_quiet: got %0d strobes ready %b expected 0 1", strobes, cmd_ready); end
    e = '0; e.addr = 32'h0FFC; e.wdata = 32'hCAFE_F00D; e.sp_data = 32'h0FFC; e.ready_at = 4;
    exp_q.push_back(e);
    run_cmd(OP_PUSH, 32'hCAFE_F00D, 32'h1000, 32'h0, 32'h0, 0, 1'b0, o);
    e = exp_q.pop_front();
    checks++; if (o.addr !== e.addr || o.wdata !== e.wdata || o.sp_data !== e.sp_data || o.ready_at != e.ready_at) begin
      fails++; $display("FAIL rst_mid_push: got %h<=%h sp %h ready %0d expected %h<=%h sp %h ready %0d",
                        o.addr, o.wdata, o.sp_data, o.ready_at, e.addr, e.wdata, e.sp_data, e.ready_at); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [3];
    obs_t o, e;
    for (int i = 0; i < 3; i++) begin
      d[i] = $urandom;
      e = '0; e.addr = 32'h1000 - 32'(4 * (i + 1)); e.wdata = d[i]; e.sp_data = e.addr; e.ready_at = 4;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      e = '0; e.addr = 32'h0FF4 + 32'(4 * i); e.pop_data = d[2 - i]; e.sp_data = e.addr + 32'd4; e.ready_at = 4 + i;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      run_cmd(OP_PUSH, d[i], 32'h1000 - 32'(4 * i), 32'h0, 32'h0, 0, 1'b0, o);
      e = exp_q.pop_front();
      checks++; if (o.addr !== e.addr || o.wdata !== e.wdata || o.sp_data !== e.sp_data || o.ready_at != e.ready_at) begin
        fails++; $display("FAIL b2b_push[%0d]: got %h<=%h sp %h ready %0d expected %h<=%h sp %h ready %0d",
                          i, o.addr, o.wdata, o.sp_data, o.ready_at, e.addr, e.wdata, e.sp_data, e.ready_at); end
    end
    for (int i = 0; i < 3; i++) begin
      run_cmd(OP_POP, 32'h0, 32'h0FF4 + 32'(4 * i), 32'h0, 32'h0, i, 1'b0, o);
      e = exp_q.pop_front();
      checks++; if (o.addr !== e.addr || o.pop_data !== e.pop_data || o.sp_data !== e.sp_data || o.ready_at != e.ready_at) begin
        fails++; $display("FAIL b2b_pop[%0d]: got %h -> %h sp %h ready %0d expected %h -> %h sp %h ready %0d",
                          i, o.addr, o.pop_data, o.sp_data, o.ready_at, e.addr, e.pop_data, e.sp_data, e.ready_at); end
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop_wait();
    test_call();
    test_ret();
    test_faults();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
